// File: rtl/regfile_onehot_wr_pkg.sv
// Shared constants and helpers for the one-hot-write register file slice.
package regfile_onehot_wr_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;

    localparam logic [RF_ADDR_W-1:0] ZERO_IDX = 5'd0;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_onehot(input logic [RF_DEPTH-1:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_onehot_wr_onehot_to_idx.sv
// Re-encodes a 32-bit decoder select into an index with legality flags.
module onehot_to_idx
    import regfile_onehot_wr_pkg::*;
(
    input  logic [RF_DEPTH-1:0]  onehot,
    output logic [RF_ADDR_W-1:0] idx,
    output logic                 valid,
    output logic                 multi
);

    logic [RF_ADDR_W-1:0] idx_s;

    // OR of set-bit positions; only meaningful when exactly one bit is set.
    always_comb begin
        idx_s = '0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            if (onehot[i]) begin
                idx_s = idx_s | i[RF_ADDR_W-1:0];
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign idx   = idx_s;
    assign valid = is_onehot(onehot);
    assign multi = (onehot != 32'd0) && !is_onehot(onehot);

endmodule

// File: rtl/regfile_onehot_wr.sv
// 32-entry register file written through a one-hot select, with two
// registered read ports, write bypass, sticky select-error flag and write counter.
module regfile_onehot_wr
    import regfile_onehot_wr_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RF_DEPTH-1:0]  we_onehot,
    input  logic [WIDTH-1:0]     wd,
    input  logic [RF_ADDR_W-1:0] ra1,
    input  logic [RF_ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2,
    output logic                 onehot_err,
    output logic [15:0]          wr_cnt
);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     rd1_q, rd1_d;
    logic [WIDTH-1:0]     rd2_q, rd2_d;
    logic                 onehot_err_q, onehot_err_d;
    logic [15:0]          wr_cnt_q, wr_cnt_d;
    logic [RF_ADDR_W-1:0] idx_s;
    logic                 valid_s, multi_s, commit_s;

    onehot_to_idx u_dec (
        .onehot (we_onehot),
        .idx    (idx_s),
        .valid  (valid_s),
        .multi  (multi_s)
    );

    assign commit_s = valid_s && !((ZERO_REG != 0) && (idx_s == ZERO_IDX));

    // Next-state: read mux with zero-register and same-cycle bypass, flag, counter.
    always_comb begin
        rd1_d        = regs_q[ra1];
        rd2_d        = regs_q[ra2];
        onehot_err_d = onehot_err_q | multi_s;
        wr_cnt_d     = wr_cnt_q;
        if ((ZERO_REG != 0) && (ra1 == ZERO_IDX)) begin
            rd1_d = '0;
        end else if (commit_s && (idx_s == ra1)) begin
            rd1_d = wd;
        end else begin
            rd1_d = regs_q[ra1];
        end
        if ((ZERO_REG != 0) && (ra2 == ZERO_IDX)) begin
            rd2_d = '0;
        end else if (commit_s && (idx_s == ra2)) begin
            rd2_d = wd;
        end else begin
            rd2_d = regs_q[ra2];
        end
        if (commit_s) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // State update; reset overrides any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q        <= '0;
            rd2_q        <= '0;
            onehot_err_q <= 1'b0;
            wr_cnt_q     <= 16'd0;
        end else begin
            if (commit_s) begin
                regs_q[idx_s] <= wd;
            end
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            onehot_err_q <= onehot_err_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign rd1        = rd1_q;
    assign rd2        = rd2_q;
    assign onehot_err = onehot_err_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench for regfile_onehot_wr.
module tb_regfile_onehot_wr;

    logic        clk;
    logic        rst;
    logic [31:0] we_onehot;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        onehot_err;
    logic [15:0] wr_cnt;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_cnt;

    regfile_onehot_wr #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .we_onehot  (we_onehot),
        .wd         (wd),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .onehot_err (onehot_err),
        .wr_cnt     (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        we_onehot = 32'h0000_0020; wd = 32'h5555_5555; tick();
        we_onehot = 32'h8000_0000; wd = 32'h3131_3131; tick();
        we_onehot = 32'h0000_0300; wd = 32'h0; tick();
        rst = 1'b1;
        we_onehot = 32'h0000_0020; wd = 32'h7777_7777;
        ra1 = 5'd5; ra2 = 5'd31;
        tick(); tick();
        tests_run++;
        if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd1: got %h expected %h", rd1, 32'h0); end
        tests_run++;
        if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd2: got %h expected %h", rd2, 32'h0); end
        tests_run++;
        if (wr_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt: got %h expected %h", wr_cnt, 16'h0); end
        tests_run++;
        if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected %b", onehot_err, 1'b0); end
        rst = 1'b0; we_onehot = 32'h0;
        tick();
        tests_run++;
        if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL reset_reg5_cleared: got %h expected %h", rd1, 32'h0); end
        tests_run++;
        if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL reset_reg31_cleared: got %h expected %h", rd2, 32'h0); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_basic();
        we_onehot = 32'h0000_0020; wd = 32'hDEAD_BEEF; ra1 = 5'd1; ra2 = 5'd2;
        tick(); exp_cnt = exp_cnt + 16'd1;
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL basic_cnt: got %h expected %h", wr_cnt, exp_cnt); end
        we_onehot = 32'h0; ra1 = 5'd5;
        tick();
        tests_run++;
        if (rd1 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL basic_read: got %h expected %h", rd1, 32'hDEAD_BEEF); end
        tests_run++;
        if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL basic_no_err: got %b expected %b", onehot_err, 1'b0); end
    endtask

    task automatic test_bypass();
        we_onehot = 32'h8000_0000; wd = 32'h1234_5678; ra1 = 5'd31; ra2 = 5'd31;
        tick(); exp_cnt = exp_cnt + 16'd1;
        tests_run++;
        if (rd1 !== 32'h1234_5678) begin tests_failed++; $display("FAIL bypass_rd1: got %h expected %h", rd1, 32'h1234_5678); end
        tests_run++;
        if (rd2 !== 32'h1234_5678) begin tests_failed++; $display("FAIL bypass_rd2: got %h expected %h", rd2, 32'h1234_5678); end
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL bypass_cnt: got %h expected %h", wr_cnt, exp_cnt); end
    endtask

    task automatic test_zero_reg();
        we_onehot = 32'h0000_0001; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd31;
        tick();
        tests_run++;
        if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL zero_same_cycle: got %h expected %h", rd1, 32'h0); end
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL zero_cnt: got %h expected %h", wr_cnt, exp_cnt); end
        we_onehot = 32'h0;
        tick();
        tests_run++;
        if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL zero_next_cycle: got %h expected %h", rd1, 32'h0); end
    endtask

    task automatic test_illegal();
        we_onehot = 32'h0000_0002; wd = 32'h1111_1111; tick();
        we_onehot = 32'h0000_0004; wd = 32'h2222_2222; tick();
        exp_cnt = exp_cnt + 16'd2;
        we_onehot = 32'h0000_0006; wd = 32'hAAAA_AAAA; ra1 = 5'd1; ra2 = 5'd2;
        tick();
        tests_run++;
        if (onehot_err !== 1'b1) begin tests_failed++; $display("FAIL illegal_err: got %b expected %b", onehot_err, 1'b1); end
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL illegal_cnt: got %h expected %h", wr_cnt, exp_cnt); end
        tests_run++;
        if (rd1 !== 32'h1111_1111) begin tests_failed++; $display("FAIL illegal_no_bypass1: got %h expected %h", rd1, 32'h1111_1111); end
        we_onehot = 32'h0;
        tick();
        tests_run++;
        if (rd1 !== 32'h1111_1111) begin tests_failed++; $display("FAIL illegal_reg1_kept: got %h expected %h", rd1, 32'h1111_1111); end
        tests_run++;
        if (rd2 !== 32'h2222_2222) begin tests_failed++; $display("FAIL illegal_reg2_kept: got %h expected %h", rd2, 32'h2222_2222); end
        we_onehot = 32'h0000_0008; wd = 32'h3333_3333; tick();
        exp_cnt = exp_cnt + 16'd1;
        we_onehot = 32'h0; ra1 = 5'd3; tick();
        tests_run++;
        if (rd1 !== 32'h3333_3333) begin tests_failed++; $display("FAIL illegal_then_legal: got %h expected %h", rd1, 32'h3333_3333); end
        tests_run++;
        if (onehot_err !== 1'b1) begin tests_failed++; $display("FAIL illegal_sticky: got %b expected %b", onehot_err, 1'b1); end
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL illegal_legal_cnt: got %h expected %h", wr_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev_wd;
        prev_wd = 32'h0;
        for (int i = 8; i < 16; i++) begin
            we_onehot = 32'd1 << i;
            wd = 32'hB000_0000 | i;
            ra1 = 5'(i - 1);
            ra2 = 5'(i);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            if (i > 8) begin
                tests_run++;
                if (rd1 !== prev_wd) begin tests_failed++; $display("FAIL b2b_prev[%0d]: got %h expected %h", i, rd1, prev_wd); end
            end
            tests_run++;
            if (rd2 !== (32'hB000_0000 | i)) begin tests_failed++; $display("FAIL b2b_bypass[%0d]: got %h expected %h", i, rd2, 32'hB000_0000 | i); end
            prev_wd = 32'hB000_0000 | i;
        end
        we_onehot = 32'h0;
        tests_run++;
        if (wr_cnt !== exp_cnt) begin tests_failed++; $display("FAIL b2b_cnt: got %h expected %h", wr_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; we_onehot = 32'h0; tick(); rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            we_onehot = 32'h0000_0080; wd = i; tick();
        end
        tests_run++;
        if (wr_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_pre: got %h expected %h", wr_cnt, 16'hFFFF); end
        wd = 32'hCAFE_F00D; tick();
        we_onehot = 32'h0;
        tests_run++;
        if (wr_cnt !== 16'h0000) begin tests_failed++; $display("FAIL wrap_cnt: got %h expected %h", wr_cnt, 16'h0000); end
        ra1 = 5'd7; tick();
        tests_run++;
        if (rd1 !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL wrap_reg7: got %h expected %h", rd1, 32'hCAFE_F00D); end
        tests_run++;
        if (onehot_err !== 1'b0) begin tests_failed++; $display("FAIL wrap_err_clear: got %b expected %b", onehot_err, 1'b0); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_cnt = 16'd0;
        rst = 1'b1; we_onehot = 32'h0; wd = 32'h0; ra1 = 5'd0; ra2 = 5'd0;
        tick(); tick();
        test_reset();
        test_basic();
        test_bypass();
        test_zero_reg();
        test_illegal();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
